// File: rtl/ram_access_scheduler.sv
// RAM access scheduler: arbitrates one memory port between SDRAM refresh,
// CPU bus accesses and ROM-download byte writes.
//
// Handshakes (all outputs registered except memory_access_ready):
//   mem_req/mem_we/mem_addr/mem_wdata are held stable from grant until the
//   cycle mem_ack is sampled high; refresh_req is held until refresh_ack.
//   Acks arriving while the matching access is not in flight are ignored.
//   Every completed access spends one cycle in IDLE before the next grant.
module ram_access_scheduler #(
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] address,
    input  logic [7:0]  internal_data_bus,
    input  logic        memory_read_n,
    input  logic        memory_write_n,
    input  logic        ram_address_select_n,
    input  logic        no_command_state,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        refresh_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        refresh_req,
    output logic [7:0]  data_bus_out,
    output logic        memory_access_ready,
    output logic        ioctl_wait,
    output logic        ioctl_overrun
);

    localparam int CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_INTERVAL - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFRESH = 2'd1,
        BUS     = 2'd2,
        DL      = 2'd3
    } state_t;

    state_t          state_q;

    // Refresh timing
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            cnt_wrap;
    logic            ref_pend_q;

    // Bus side
    logic            rd_prev_q;
    logic            wr_prev_q;
    logic            bus_start;
    logic            bus_pend_q;
    logic [19:0]     bus_addr_q;
    logic [7:0]      bus_wdata_q;
    logic            bus_we_q;
    logic            bus_done_q;
    logic [7:0]      data_bus_out_q;

    // Download buffer
    logic            dl_full_q;
    logic [19:0]     dl_addr_q;
    logic [7:0]      dl_data_q;
    logic            dl_overrun_q;

    // Registered memory-port outputs
    logic            mem_req_q;
    logic            mem_we_q;
    logic [19:0]     mem_addr_q;
    logic [7:0]      mem_wdata_q;
    logic            refresh_req_q;

    // Acks qualified by the state that is waiting for them
    logic            ref_ack_ok;
    logic            bus_ack_ok;
    logic            dl_ack_ok;

    // Upper download address bits lie outside the 1 MiB RAM window
    logic            unused_ioctl_addr_hi;
    assign unused_ioctl_addr_hi = ^ioctl_addr[24:20];

    assign ref_ack_ok = (state_q == REFRESH) && refresh_ack;
    assign bus_ack_ok = (state_q == BUS) && mem_ack;
    assign dl_ack_ok  = (state_q == DL) && mem_ack;

    // New bus command: RAM selected and a strobe falls from the all-high idle
    assign bus_start = !ram_address_select_n
                     && (!memory_read_n || !memory_write_n)
                     && rd_prev_q && wr_prev_q;

    // Refresh interval counter next state and wrap detect
    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_wrap) begin
            cnt_d = '0;
        end
    end

    // Refresh counter and saturating refresh-pending flag
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_wrap) begin
                ref_pend_q <= 1'b1;
            end else if (ref_ack_ok) begin
                ref_pend_q <= 1'b0;
            end
        end
    end

    // Bus strobe edge tracking, command latch, completion flag and read data
    always_ff @(posedge clock) begin
        if (reset) begin
            // Strobe history resets low so a strobe still held across reset
            // is not taken as a fresh command (abandoned accesses never retry).
            rd_prev_q      <= 1'b0;
            wr_prev_q      <= 1'b0;
            bus_pend_q     <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            bus_we_q       <= 1'b0;
            bus_done_q     <= 1'b0;
            data_bus_out_q <= '0;
        end else begin
            rd_prev_q <= memory_read_n;
            wr_prev_q <= memory_write_n;
            if (bus_ack_ok) begin
                bus_pend_q <= 1'b0;
            end else if (bus_start && !bus_pend_q) begin
                bus_pend_q  <= 1'b1;
                bus_addr_q  <= address;
                bus_wdata_q <= internal_data_bus;
                bus_we_q    <= !memory_write_n;
            end
            if (bus_ack_ok) begin
                bus_done_q <= 1'b1;
            end else if (no_command_state || (memory_read_n && memory_write_n)) begin
                bus_done_q <= 1'b0;
            end
            if (bus_ack_ok && !bus_we_q) begin
                data_bus_out_q <= mem_rdata;
            end
        end
    end

    // One-byte download buffer with sticky overrun on any write while full
    always_ff @(posedge clock) begin
        if (reset) begin
            dl_full_q    <= 1'b0;
            dl_addr_q    <= '0;
            dl_data_q    <= '0;
            dl_overrun_q <= 1'b0;
        end else begin
            if (ioctl_wr && dl_full_q) begin
                dl_overrun_q <= 1'b1;
            end
            if (dl_ack_ok) begin
                dl_full_q <= 1'b0;
            end else if (ioctl_wr && ioctl_download && !dl_full_q) begin
                dl_full_q <= 1'b1;
                dl_addr_q <= ioctl_addr[19:0];
                dl_data_q <= ioctl_data;
            end
        end
    end

    // Arbiter FSM: one grant per IDLE visit, refresh > bus > download
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            refresh_req_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ref_pend_q) begin
                        state_q       <= REFRESH;
                        refresh_req_q <= 1'b1;
                    end else if (bus_pend_q) begin
                        state_q     <= BUS;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus_we_q;
                        mem_addr_q  <= bus_addr_q;
                        mem_wdata_q <= bus_wdata_q;
                    end else if (dl_full_q) begin
                        state_q     <= DL;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= dl_addr_q;
                        mem_wdata_q <= dl_data_q;
                    end
                end
                REFRESH: begin
                    if (refresh_ack) begin
                        state_q       <= IDLE;
                        refresh_req_q <= 1'b0;
                    end
                end
                BUS, DL: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Wait-state request straight from the bus so the CPU stalls in the same cycle
    assign memory_access_ready = reset
                               || !(!ram_address_select_n
                                    && (!memory_read_n || !memory_write_n)
                                    && !bus_done_q);

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign refresh_req   = refresh_req_q;
    assign data_bus_out  = data_bus_out_q;
    assign ioctl_wait    = dl_full_q;
    assign ioctl_overrun = dl_overrun_q;

endmodule

// File: tb/tb_ram_access_scheduler.sv
// Directed bench for ram_access_scheduler. Two instances: dut_a with a long
// refresh interval for bus/download traffic, dut_r with an 8-cycle interval
// for refresh arbitration and cadence.
module tb_ram_access_scheduler;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;

    // ---------------- dut_a signals ----------------
    logic        rst;
    logic [19:0] address;
    logic [7:0]  idb;
    logic        rd_n, wr_n, sel_n, nocmd;
    logic        dl, dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        refresh_ack;
    logic        mem_req, mem_we, refresh_req, ready, ioctl_wait, overrun;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata, dbo;

    // ---------------- dut_r signals ----------------
    logic        r_rst;
    logic [19:0] r_address;
    logic [7:0]  r_idb;
    logic        r_rd_n, r_wr_n, r_sel_n, r_nocmd;
    logic        r_dl, r_dl_wr;
    logic [24:0] r_dl_addr;
    logic [7:0]  r_dl_data;
    logic        r_mem_ack;
    logic [7:0]  r_mem_rdata;
    logic        r_refresh_ack;
    logic        r_mem_req, r_mem_we, r_refresh_req, r_ready, r_ioctl_wait, r_overrun;
    logic [19:0] r_mem_addr;
    logic [7:0]  r_mem_wdata, r_dbo;

    ram_access_scheduler #(.REFRESH_INTERVAL(4096)) dut_a (
        .clock(clock), .reset(rst),
        .address(address), .internal_data_bus(idb),
        .memory_read_n(rd_n), .memory_write_n(wr_n),
        .ram_address_select_n(sel_n), .no_command_state(nocmd),
        .ioctl_download(dl), .ioctl_wr(dl_wr), .ioctl_addr(dl_addr), .ioctl_data(dl_data),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .refresh_ack(refresh_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .refresh_req(refresh_req), .data_bus_out(dbo),
        .memory_access_ready(ready), .ioctl_wait(ioctl_wait), .ioctl_overrun(overrun)
    );

    ram_access_scheduler #(.REFRESH_INTERVAL(8)) dut_r (
        .clock(clock), .reset(r_rst),
        .address(r_address), .internal_data_bus(r_idb),
        .memory_read_n(r_rd_n), .memory_write_n(r_wr_n),
        .ram_address_select_n(r_sel_n), .no_command_state(r_nocmd),
        .ioctl_download(r_dl), .ioctl_wr(r_dl_wr), .ioctl_addr(r_dl_addr), .ioctl_data(r_dl_data),
        .mem_ack(r_mem_ack), .mem_rdata(r_mem_rdata), .refresh_ack(r_refresh_ack),
        .mem_req(r_mem_req), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
        .refresh_req(r_refresh_req), .data_bus_out(r_dbo),
        .memory_access_ready(r_ready), .ioctl_wait(r_ioctl_wait), .ioctl_overrun(r_overrun)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; address = '0; idb = '0; rd_n = 1'b1; wr_n = 1'b1; sel_n = 1'b1;
        nocmd = 1'b0; dl = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        mem_ack = 1'b0; mem_rdata = '0; refresh_ack = 1'b0;
        r_rst = 1'b1; r_address = '0; r_idb = '0; r_rd_n = 1'b1; r_wr_n = 1'b1; r_sel_n = 1'b1;
        r_nocmd = 1'b0; r_dl = 1'b0; r_dl_wr = 1'b0; r_dl_addr = '0; r_dl_data = '0;
        r_mem_ack = 1'b0; r_mem_rdata = '0; r_refresh_ack = 1'b0;

        tick();
        tick();

        // ---- reset state ----
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_refresh_req", refresh_req, 0);
        chk("rst_dbo", dbo, 0);
        chk("rst_ready", ready, 1);
        chk("rst_ioctl_wait", ioctl_wait, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // ---- bus read 0x12345, ack three cycles after strobe ----
        sel_n = 1'b0; rd_n = 1'b0; address = 20'h12345;
        #1 chk("rd_ready_c0", ready, 0);
        tick();
        chk("rd_ready_c1", ready, 0);
        chk("rd_req_c1", mem_req, 0);
        tick();
        chk("rd_ready_c2", ready, 0);
        chk("rd_req_c2", mem_req, 1);
        chk("rd_we_c2", mem_we, 0);
        chk("rd_addr_c2", mem_addr, 32'h12345);
        tick();
        chk("rd_ready_c3", ready, 0);
        chk("rd_req_c3", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 8'hA5;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'hFF;
        chk("rd_ready_c4", ready, 1);
        chk("rd_dbo", dbo, 32'hA5);
        chk("rd_req_done", mem_req, 0);
        tick();
        chk("rd_ready_c5", ready, 1);
        tick();
        chk("rd_ready_c6", ready, 1);
        chk("rd_dbo_hold", dbo, 32'hA5);
        nocmd = 1'b1;
        #1 chk("rd_ready_nocmd_same", ready, 1);
        tick();
        chk("rd_ready_done_clr", ready, 0);
        chk("rd_no_retry", mem_req, 0);
        rd_n = 1'b1; sel_n = 1'b1; nocmd = 1'b0;
        #1 chk("idle_ready", ready, 1);

        // ---- strobe with RAM not selected ----
        rd_n = 1'b0;
        #1 chk("nosel_ready", ready, 1);
        tick();
        tick();
        chk("nosel_no_req", mem_req, 0);
        rd_n = 1'b1;
        tick();

        // ---- bus write: read data bus must hold ----
        sel_n = 1'b0; wr_n = 1'b0; address = 20'h00777; idb = 8'h99;
        tick();
        tick();
        chk("wr_req", mem_req, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 32'h00777);
        chk("wr_wdata", mem_wdata, 32'h99);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        tick();
        mem_ack = 1'b0;
        chk("wr_dbo_hold", dbo, 32'hA5);
        chk("wr_ready", ready, 1);
        chk("wr_req_done", mem_req, 0);
        wr_n = 1'b1; sel_n = 1'b1;
        tick();

        // ---- download byte, then a byte while full ----
        dl = 1'b1; dl_wr = 1'b1; dl_addr = 25'h1A0F000; dl_data = 8'h3C;
        tick();
        dl_wr = 1'b0;
        chk("dl_wait", ioctl_wait, 1);
        chk("dl_req_c1", mem_req, 0);
        tick();
        chk("dl_req", mem_req, 1);
        chk("dl_we", mem_we, 1);
        chk("dl_addr", mem_addr, 32'h0F000);
        chk("dl_wdata", mem_wdata, 32'h3C);
        dl_wr = 1'b1; dl_addr = 25'h0000001; dl_data = 8'h77;
        tick();
        dl_wr = 1'b0;
        chk("ovr_set", overrun, 1);
        chk("ovr_addr_intact", mem_addr, 32'h0F000);
        chk("ovr_wdata_intact", mem_wdata, 32'h3C);
        chk("ovr_wait", ioctl_wait, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("dl_wait_clr", ioctl_wait, 0);
        chk("dl_req_done", mem_req, 0);
        tick();
        chk("ovr_byte_dropped", mem_req, 0);
        chk("ovr_sticky", overrun, 1);

        // ---- download disabled while buffer full: still drains ----
        dl_wr = 1'b1; dl_addr = 25'h0000100; dl_data = 8'hC3;
        tick();
        dl_wr = 1'b0; dl = 1'b0;
        chk("drain_wait", ioctl_wait, 1);
        tick();
        chk("drain_req", mem_req, 1);
        chk("drain_addr", mem_addr, 32'h00100);
        chk("drain_wdata", mem_wdata, 32'hC3);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("drain_wait_clr", ioctl_wait, 0);
        dl_wr = 1'b1; dl_data = 8'h55;
        tick();
        dl_wr = 1'b0;
        chk("nodl_ignored", ioctl_wait, 0);

        // ---- write in the DL ack cycle is dropped ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ovr_clr", overrun, 0);
        dl = 1'b1; dl_wr = 1'b1; dl_addr = 25'h0000200; dl_data = 8'h81;
        tick();
        dl_wr = 1'b0;
        tick();
        chk("ackdrop_req", mem_req, 1);
        chk("ackdrop_addr", mem_addr, 32'h00200);
        mem_ack = 1'b1; dl_wr = 1'b1; dl_addr = 25'h0000300; dl_data = 8'h42;
        tick();
        mem_ack = 1'b0; dl_wr = 1'b0;
        chk("ackdrop_ovr", overrun, 1);
        chk("ackdrop_wait", ioctl_wait, 0);
        tick();
        chk("ackdrop_no_req", mem_req, 0);

        // ---- bus beats download, one IDLE cycle between grants ----
        sel_n = 1'b0; wr_n = 1'b0; address = 20'h00ABC; idb = 8'h12;
        dl_wr = 1'b1; dl_addr = 25'h0000DEF; dl_data = 8'h34;
        tick();
        dl_wr = 1'b0;
        tick();
        chk("prio_bus_req", mem_req, 1);
        chk("prio_bus_addr", mem_addr, 32'h00ABC);
        chk("prio_bus_wdata", mem_wdata, 32'h12);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("prio_idle_gap", mem_req, 0);
        tick();
        chk("prio_dl_req", mem_req, 1);
        chk("prio_dl_addr", mem_addr, 32'h00DEF);
        chk("prio_dl_wdata", mem_wdata, 32'h34);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        wr_n = 1'b1; sel_n = 1'b1;

        // ---- reset during a bus access ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        sel_n = 1'b0; rd_n = 1'b0; address = 20'h54321;
        tick();
        tick();
        chk("rstbus_req", mem_req, 1);
        rst = 1'b1;
        tick();
        chk("rstbus_req_drop", mem_req, 0);
        chk("rstbus_ready", ready, 1);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h5F;
        tick();
        mem_ack = 1'b0;
        chk("rstbus_stale_ack_dbo", dbo, 0);
        chk("rstbus_no_req", mem_req, 0);
        tick();
        chk("rstbus_no_retry", mem_req, 0);
        rd_n = 1'b1; sel_n = 1'b1;

        // ---- dut_r: refresh held off 20 cycles, saturation and cadence ----
        r_rst = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        chk("ref_not_yet", r_refresh_req, 0);
        tick();                                   // edge 9
        chk("ref_req", r_refresh_req, 1);
        chk("ref_no_mem_req", r_mem_req, 0);
        for (int i = 10; i <= 29; i++) begin
            tick();
            chk("ref_held", r_refresh_req, 1);
        end
        r_refresh_ack = 1'b1;
        tick();                                   // edge 30
        r_refresh_ack = 1'b0;
        chk("ref_ack_drop", r_refresh_req, 0);
        tick();                                   // edge 31
        chk("ref_saturated", r_refresh_req, 0);
        tick();                                   // edge 32
        chk("ref_wait_wrap", r_refresh_req, 0);
        tick();                                   // edge 33
        chk("ref_next", r_refresh_req, 1);
        r_refresh_ack = 1'b1;
        tick();                                   // edge 34
        r_refresh_ack = 1'b0;
        chk("ref_ack2", r_refresh_req, 0);
        for (int i = 35; i <= 40; i++) begin
            tick();
            chk("ref_gap", r_refresh_req, 0);
        end
        tick();                                   // edge 41
        chk("ref_cadence", r_refresh_req, 1);
        r_refresh_ack = 1'b1;
        tick();
        r_refresh_ack = 1'b0;

        // ---- dut_r: refresh expiry and bus write in the same cycle ----
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        r_sel_n = 1'b0; r_wr_n = 1'b0; r_address = 20'h0ABCD; r_idb = 8'h5A;
        tick();                                   // edge 8: both pending
        chk("both_no_grant_yet", r_refresh_req, 0);
        tick();                                   // edge 9
        chk("both_refresh_first", r_refresh_req, 1);
        chk("both_no_mem_req", r_mem_req, 0);
        r_refresh_ack = 1'b1;
        tick();                                   // edge 10
        r_refresh_ack = 1'b0;
        chk("both_ref_done", r_refresh_req, 0);
        chk("both_idle_gap", r_mem_req, 0);
        tick();                                   // edge 11
        chk("both_mem_req", r_mem_req, 1);
        chk("both_mem_we", r_mem_we, 1);
        chk("both_mem_addr", r_mem_addr, 32'h0ABCD);
        chk("both_mem_wdata", r_mem_wdata, 32'h5A);
        chk("both_exclusive", r_refresh_req, 0);
        chk("both_ready_low", r_ready, 0);
        r_mem_ack = 1'b1;
        tick();
        r_mem_ack = 1'b0;
        chk("both_done_req", r_mem_req, 0);
        chk("both_ready_high", r_ready, 1);
        r_wr_n = 1'b1; r_sel_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
